// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and the per-edge fetch operation encoding.
// Imported by the fetch stage, decode stage and hazard unit.
package fetch_stage_pkg;

  localparam int unsigned    CPU_XLEN      = 32;
  localparam logic [31:0]    CPU_PC_RESET  = 32'h0000_0000;
  localparam logic [31:0]    CPU_NOP_INSTR = 32'h0000_0013;
  localparam int unsigned    CPU_CNT_W     = 32;

  // What the fetch stage does on the coming edge, in priority order.
  typedef enum logic [2:0] {
    OP_RESET,
    OP_IDLE,
    OP_FLUSH,
    OP_STALL,
    OP_NORMAL
  } fetch_op_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage control, instruction-memory and IF/ID signals.
// master = fetch stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             flush_i;
  logic [XLEN-1:0]  branch_target_i;
  logic [XLEN-1:0]  imem_addr_o;
  logic [31:0]      imem_instr_i;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  if_id_pc_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    input  start_i, stall_i, flush_i, branch_target_i, imem_instr_i,
    output imem_addr_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    output start_i, stall_i, flush_i, branch_target_i, imem_instr_i,
    input  imem_addr_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter: counts inc_i cycles, sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register and
// saturating stall/flush event counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN      = CPU_XLEN,
  parameter logic [XLEN-1:0] PC_RESET  = XLEN'(CPU_PC_RESET),
  parameter int unsigned     CNT_W     = CPU_CNT_W,
  parameter logic [31:0]     NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_if_id_pc;
  logic [31:0]     r_if_id_instr;
  logic            r_if_id_valid;

  fetch_op_e       w_op;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_target_aligned;
  logic            w_stall_inc;
  logic            w_flush_inc;

  // Redirect targets are forced word-aligned so the low PC bits stay zero.
  assign w_target_aligned = {bus.branch_target_i[XLEN-1:2], 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_op = OP_NORMAL;
    if (rst_i)              w_op = OP_RESET;
    else if (!bus.start_i)  w_op = OP_IDLE;
    else if (bus.flush_i)   w_op = OP_FLUSH;
    else if (bus.stall_i)   w_op = OP_STALL;
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_op)
      OP_RESET:  w_pc_next = PC_RESET;
      OP_FLUSH:  w_pc_next = w_target_aligned;
      OP_NORMAL: w_pc_next = r_pc + XLEN'(4);
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk_i) begin
    r_pc <= w_pc_next;
    case (w_op)
      OP_RESET, OP_IDLE, OP_FLUSH: begin
        r_if_id_pc    <= '0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end
      OP_NORMAL: begin
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= bus.imem_instr_i;
        r_if_id_valid <= 1'b1;
      end
      default: begin
        r_if_id_pc    <= r_if_id_pc;
        r_if_id_instr <= r_if_id_instr;
        r_if_id_valid <= r_if_id_valid;
      end
    endcase
  end

  // A flush outranks a stall, so a stall cycle only counts when no flush is active.
  assign w_stall_inc = (w_op == OP_STALL);
  assign w_flush_inc = (w_op == OP_FLUSH);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_inc),
    .cnt_o (bus.flush_cnt_o)
  );

  assign bus.imem_addr_o   = r_pc;
  assign bus.pc_o          = r_pc;
  assign bus.if_id_pc_o    = r_if_id_pc;
  assign bus.if_id_instr_o = r_if_id_instr;
  assign bus.if_id_valid_o = r_if_id_valid;

endmodule
